// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and default datapath width
// for the multicycle ALU.
package alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MULTU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide datapath.
// One step per cycle while the counter is non-zero; res_* expose the step result.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    localparam int CW = $clog2(WIDTH + 1);

    // hi: product high / remainder; lo: multiplier / quotient; opnd: multiplicand / divisor
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
    logic             div_q, div_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   sum_s, shl_s, diff_s;
    logic             fits_s;
    logic [WIDTH-1:0] step_hi_s, step_lo_s;

    // Single multiply or divide step computed from the current partial state
    always_comb begin
        sum_s  = lo_q[0] ? ({1'b0, hi_q} + {1'b0, opnd_q}) : {1'b0, hi_q};
        shl_s  = {hi_q, lo_q[WIDTH-1]};
        fits_s = (shl_s >= {1'b0, opnd_q});
        diff_s = shl_s - {1'b0, opnd_q};
        if (div_q) begin
            step_hi_s = fits_s ? diff_s[WIDTH-1:0] : shl_s[WIDTH-1:0];
            step_lo_s = {lo_q[WIDTH-2:0], fits_s};
        end else begin
            step_hi_s = sum_s[WIDTH:1];
            step_lo_s = {sum_s[0], lo_q[WIDTH-1:1]};
        end
    end

    // Load operands on request, otherwise advance while steps remain
    always_comb begin
        hi_d   = hi_q;
        lo_d   = lo_q;
        opnd_d = opnd_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        if (load) begin
            hi_d   = '0;
            lo_d   = op_a;
            opnd_d = op_b;
            div_d  = is_div;
            cnt_d  = CW'(WIDTH);
        end else if (cnt_q != '0) begin
            hi_d  = step_hi_s;
            lo_d  = step_lo_s;
            cnt_d = cnt_q - CW'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Partial-result and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            opnd_q <= '0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            opnd_q <= opnd_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
        end
    end

    assign last   = (cnt_q == CW'(1));
    assign res_hi = step_hi_s;
    assign res_lo = step_lo_s;

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle ALU top: IDLE/RUN/DONE control, single-cycle operations and
// registered result outputs; MULTU/DIVU iterate in alu_muldiv_iter.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int SLT_SIGNED = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic [WIDTH-1:0] aluResult,
    output logic [WIDTH-1:0] hiResult,
    output logic             zero,
    output logic             overflow,
    output logic             divZero,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] alu_q, alu_d, hi_q, hi_d;
    logic             zero_q, zero_d, ovf_q, ovf_d, dz_q, dz_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [WIDTH-1:0] sc_lo_s, sc_hi_s, sum_s, dif_s;
    logic             sc_ovf_s, sc_dz_s, slt_s, div0_s;
    logic             iter_load_s, iter_last_s;
    logic [WIDTH-1:0] iter_hi_s, iter_lo_s;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .load   (iter_load_s),
        .is_div (operation == OP_DIVU),
        .op_a   (data1),
        .op_b   (data2),
        .last   (iter_last_s),
        .res_hi (iter_hi_s),
        .res_lo (iter_lo_s)
    );

    // Single-cycle results from the live inputs, including the divide-by-zero shortcut
    always_comb begin
        sum_s    = data1 + data2;
        dif_s    = data1 - data2;
        slt_s    = (SLT_SIGNED != 0) ? ($signed(data1) < $signed(data2)) : (data1 < data2);
        div0_s   = (operation == OP_DIVU) && (data2 == '0);
        sc_lo_s  = '0;
        sc_hi_s  = '0;
        sc_ovf_s = 1'b0;
        sc_dz_s  = 1'b0;
        case (operation)
            OP_AND: sc_lo_s = data1 & data2;
            OP_OR:  sc_lo_s = data1 | data2;
            OP_XOR: sc_lo_s = data1 ^ data2;
            OP_NOR: sc_lo_s = ~(data1 | data2);
            OP_SLT: sc_lo_s = {{(WIDTH-1){1'b0}}, slt_s};
            OP_ADD: begin
                sc_lo_s  = sum_s;
                sc_ovf_s = (data1[WIDTH-1] == data2[WIDTH-1]) && (sum_s[WIDTH-1] != data1[WIDTH-1]);
            end
            OP_SUB: begin
                sc_lo_s  = dif_s;
                sc_ovf_s = (data1[WIDTH-1] != data2[WIDTH-1]) && (dif_s[WIDTH-1] != data1[WIDTH-1]);
            end
            OP_DIVU: begin
                sc_lo_s = '1;
                sc_hi_s = data1;
                sc_dz_s = 1'b1;
            end
            default: sc_lo_s = '0;
        endcase
    end

    // Next-state and output-register logic; DONE accepts a new start like IDLE
    always_comb begin
        state_d     = state_q;
        alu_d       = alu_q;
        hi_d        = hi_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        dz_d        = dz_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        iter_load_s = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end else if (is_iter_op(operation) && !div0_s) begin
                    iter_load_s = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = RUN;
                end else begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    alu_d   = sc_lo_s;
                    hi_d    = sc_hi_s;
                    zero_d  = (sc_lo_s == '0);
                    ovf_d   = sc_ovf_s;
                    dz_d    = sc_dz_s;
                end
            end
            RUN: begin
                if (iter_last_s) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    alu_d   = iter_lo_s;
                    hi_d    = iter_hi_s;
                    zero_d  = (iter_lo_s == '0);
                    ovf_d   = 1'b0;
                    dz_d    = 1'b0;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            alu_q   <= '0;
            hi_q    <= '0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            alu_q   <= alu_d;
            hi_q    <= hi_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign aluResult = alu_q;
    assign hiResult  = hi_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign divZero   = dz_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: expectations are queued when a start
// is driven and compared, including completion cycle, on each done pulse.
module tb_alu_multicycle;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [3:0]   operation;
    logic [W-1:0] data1, data2, aluResult, hiResult;
    logic         zero, overflow, divZero, busy, done;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         zero;
        logic         ovf;
        logic         dz;
        int           due;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    alu_multicycle #(.WIDTH(W), .SLT_SIGNED(1)) dut (
        .clk(clk), .reset(reset), .start(start), .operation(operation),
        .data1(data1), .data2(data2), .aluResult(aluResult), .hiResult(hiResult),
        .zero(zero), .overflow(overflow), .divZero(divZero), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] p;
        logic [W-1:0] s;
        e.lo = '0; e.hi = '0; e.ovf = 1'b0; e.dz = 1'b0; e.due = 1;
        case (op)
            4'b0000: e.lo = a & b;
            4'b0001: e.lo = a | b;
            4'b0100: e.lo = a ^ b;
            4'b1100: e.lo = ~(a | b);
            4'b0111: e.lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0010: begin s = a + b; e.lo = s; e.ovf = (a[31] == b[31]) && (s[31] != a[31]); end
            4'b0110: begin s = a - b; e.lo = s; e.ovf = (a[31] != b[31]) && (s[31] != a[31]); end
            4'b1000: begin p = {32'd0, a} * {32'd0, b}; e.lo = p[31:0]; e.hi = p[63:32]; e.due = W + 1; end
            4'b1001: begin
                if (b == 32'd0) begin e.lo = 32'hFFFF_FFFF; e.hi = a; e.dz = 1'b1; end
                else begin e.lo = a / b; e.hi = a % b; e.due = W + 1; end
            end
            default: e.lo = '0;
        endcase
        e.zero = (e.lo == 32'd0);
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the following cycle
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e = model(op, a, b);
        e.due = e.due + cyc;
        sb_q.push_back(e);
        operation = op; data1 = a; data2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb_q.size() != 0; i++) tick(1);
        check_val("drain", sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic check_reset_vals();
        check_val("rst_alu", aluResult, 0);
        check_val("rst_hi", hiResult, 0);
        check_val("rst_zero", zero, 1);
        check_val("rst_ovf", overflow, 0);
        check_val("rst_dz", divZero, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
    endtask

    // Scoreboard monitor on the falling edge
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_done", done, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check_val("done_cycle", cyc, mon_e.due);
                check_val("aluResult", aluResult, mon_e.lo);
                check_val("hiResult", hiResult, mon_e.hi);
                check_val("zero", zero, mon_e.zero);
                check_val("overflow", overflow, mon_e.ovf);
                check_val("divZero", divZero, mon_e.dz);
                check_val("busy_in_done", busy, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb;
        reset = 1'b1; start = 1'b0; operation = 4'd0; data1 = '0; data2 = '0;
        tick(3);
        check_reset_vals();
        reset = 1'b0;
        tick(1);

        send(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
        drain();
        tick(3);
        check_val("hold_alu", aluResult, 32'h8000_0000);
        check_val("hold_ovf", overflow, 1);

        send(4'b0110, 32'd5, 32'd5);
        send(4'b0111, 32'hFFFF_FFFF, 32'd1);
        drain();

        send(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check_val("busy_n1", busy, 1);
        for (int k = 2; k <= 32; k++) begin
            tick(1);
            check_val("busy_run", busy, 1);
            if (k == 5) check_val("hold_during_run", aluResult, 32'd1);
        end
        tick(1);
        check_val("busy_after", busy, 0);
        drain();

        send(4'b1001, 32'd100, 32'd7);
        tick(3);
        operation = 4'b1000; data1 = 32'h0000_FFFF; data2 = 32'd3; start = 1'b1;
        tick(1);
        start = 1'b0;
        drain();

        send(4'b1001, 32'h0000_1234, 32'd0);
        drain();

        send(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00);
        send(4'b0001, 32'hF000_0000, 32'h0000_000F);
        send(4'b0100, 32'hAAAA_5555, 32'hFFFF_0000);
        send(4'b1100, 32'h0F0F_0F0F, 32'h00F0_00F0);
        send(4'b0110, 32'h8000_0000, 32'd1);
        send(4'b0010, 32'hFFFF_FFFF, 32'd1);
        send(4'b0011, 32'h1234_5678, 32'h9ABC_DEF0);
        send(4'b0111, 32'd3, 32'hFFFF_FFFE);
        drain();

        for (int r = 0; r < 3; r++) begin
            ra = $urandom; rb = $urandom_range(1, 32'h00FF_FFFF);
            send(4'b1000, ra, rb);
            tick(32);
            send(4'b1001, ra, rb);
            tick(32);
            send(4'b0010, ra, rb);
            drain();
        end

        send(4'b1000, 32'h0001_0001, 32'h0000_0300);
        tick(9);
        reset = 1'b1;
        sb_q.delete();
        tick(1);
        check_reset_vals();
        reset = 1'b0;
        send(4'b0010, 32'd2, 32'd3);
        drain();
        tick(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width in bits (legal 8..64, even).
REQ-002 The block SHALL have parameter SLT_SIGNED, default 1, 1 = signed set-less-than compare, 0 = unsigned.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; accepted only when busy=0.
REQ-006 operation  input  4  opcode, sampled with start.
REQ-007 data1  input  WIDTH  first operand, sampled with start.
REQ-008 data2  input  WIDTH  second operand, sampled with start.
REQ-009 aluResult  output  WIDTH  low result word (product low, quotient, or single-cycle result).
REQ-010 hiResult  output  WIDTH  high word: product high, remainder; 0 for single-cycle ops.
REQ-011 zero  output  1  1 when aluResult == 0.
REQ-012 overflow  output  1  signed overflow for ADD/SUB; 0 otherwise.
REQ-013 divZero  output  1  1 when a DIVU completed with data2 == 0.
REQ-014 busy  output  1  1 while an accepted operation has not completed.
REQ-015 done  output  1  one-cycle pulse; results valid from this cycle.

Function
REQ-016 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0100 XOR, 0110 SUB, 0111 SLT, 1100 NOR, 1000 MULTU, 1001 DIVU; any other code is single-cycle with all result outputs 0.
REQ-017 SLT SHALL give aluResult = 1 when data1 < data2 (signedness per SLT_SIGNED), else 0.
REQ-018 ADD/SUB SHALL wrap modulo 2^WIDTH; overflow = operand signs equal (ADD) / differ (SUB) and result sign differs from data1.
REQ-019 State machine SHALL have states IDLE, RUN, DONE; reset enters IDLE.
REQ-020 IDLE + start with single-cycle opcode: compute from live inputs, register outputs, go to DONE; done=1 the next cycle (latency 1).
REQ-021 IDLE + start with MULTU/DIVU: latch operands and opcode, load counter with WIDTH, go to RUN; busy=1 from the next cycle.
REQ-022 RUN SHALL perform one shift-add (MULTU) or one restoring subtract-shift (DIVU) step per cycle, decrementing the counter; at count 1 go to DONE.
REQ-023 MULTU/DIVU latency SHALL be WIDTH+1 cycles: start accepted in cycle N -> done=1 in cycle N+WIDTH+1.
REQ-024 MULTU SHALL output unsigned 2*WIDTH product as {hiResult, aluResult}.
REQ-025 DIVU SHALL output quotient in aluResult, remainder in hiResult.
REQ-026 DIVU with data2 == 0 SHALL skip RUN, go directly to DONE (latency 1), aluResult = all ones, hiResult = data1, divZero = 1.
REQ-027 DONE SHALL assert done for exactly one cycle and return to IDLE; busy = 0 in DONE.
REQ-028 start in DONE SHALL be accepted exactly as in IDLE (back-to-back, no bubble).
REQ-029 start while in RUN SHALL be ignored without side effect; operands and opcode changes during RUN SHALL not affect the result.
REQ-030 Result outputs, zero, overflow, divZero SHALL hold their last values until the next completion updates them; intermediate RUN values SHALL not be visible.
REQ-031 zero, overflow, divZero SHALL update in the same cycle as done.

Reset
REQ-032 reset SHALL force IDLE, counter 0, busy 0, done 0, aluResult 0, hiResult 0, zero 1, overflow 0, divZero 0 on the next edge.
REQ-033 reset asserted during RUN SHALL abort the operation with no done pulse; reset has priority over start.

Structure
REQ-034 Package alu_pkg SHALL hold opcode constants, the IDLE/RUN/DONE state enumeration, and the default WIDTH.
REQ-035 Iterative datapath SHALL be sub-module alu_muldiv_iter (operand/partial registers, step logic, counter); top holds FSM, single-cycle ops, output registers.

Verification
REQ-036 ADD 0x7FFFFFFF + 0x00000001 -> done at N+1, aluResult 0x80000000, overflow 1, zero 0.
REQ-037 SUB 5 - 5 then SLT 0xFFFFFFFF vs 1 back-to-back -> aluResult 0, zero 1; then aluResult 1 (SLT_SIGNED=1) one cycle later.
REQ-038 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at N+33, hiResult 0xFFFFFFFE, aluResult 0x00000001, busy high N+1..N+32.
REQ-039 DIVU 100 / 7 with start pulsed and data changed during RUN -> aluResult 14, hiResult 2, second start ignored.
REQ-040 DIVU 0x1234 / 0 -> done at N+1, aluResult 0xFFFFFFFF, hiResult 0x1234, divZero 1.
REQ-041 reset at cycle N+10 of a MULTU -> no done pulse, all outputs at reset values, next ADD 2+3 gives 5 at latency 1.
